uart8_echo_responder: RTL and testbench
=======================================

Name: uart8_echo_responder

Overview:
- Far-end responder for a Uart8 link. It sits between one Uart8's rx interface and the same instance's tx interface.
- Every byte received cleanly is buffered in a small FIFO and transmitted back, XORed with a mask, on the same link.
- Gives an initiator-side Uart8 a live peer for loopback and latency checks, and counts framing errors and overflows.

Parameters:
- FIFO_DEPTH, 8, echo buffer depth in bytes; power of 2, minimum 2.
- XOR_MASK, 8'h00, reply byte = received byte ^ XOR_MASK.
- DROP_ON_ERR, 1, 1 = bytes flagged by rxErr are discarded; 0 = bytes flagged by rxErr are echoed like any other byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  responder enable; gates new transmissions only.
- rxDone  in  1  from Uart8; rising edge marks rxOut valid.
- rxErr  in  1  from Uart8; framing error for the byte completing at the rxDone edge.
- rxOut  in  8  from Uart8; received byte.
- txBusy  in  1  from Uart8.
- txDone  in  1  from Uart8; informational only, not used for sequencing.
- txEn  out  1  to Uart8 tx enable.
- txStart  out  1  to Uart8.
- txIn  out  8  to Uart8; reply byte.
- fifoCount  out  $clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.
- errCount  out  8  rxErr events; saturates at 255.
- idle  out  1  high when the FSM is in IDLE and fifoCount==0.

Behaviour:
- Reset, asynchronous while reset==0:
  - txEn=0, txStart=0, txIn=0, fifoCount=0, overflow=0, errCount=0, idle=1.
  - FIFO pointers cleared, FSM in IDLE, rxDone_q=0.
  - Reset mid-transfer abandons the transfer; the Uart8 recovers on its own reset.
- Capture:
  - rxDone_q registers rxDone each cycle. A capture event is rxDone & ~rxDone_q; at most one capture per rising edge, so a level held high never re-captures.
  - On a capture with rxErr=1: errCount increments (saturating). If DROP_ON_ERR=1 the byte is discarded.
  - Otherwise the byte is pushed as rxOut ^ XOR_MASK, with the XOR applied at write time.
  - Push when full and no pop in the same cycle: byte dropped, overflow set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: accepted; fifoCount unchanged.
  - Push while empty: the byte cannot be popped in the same cycle.
- Pointers: wrap modulo FIFO_DEPTH. fifoCount is a separate counter, so the FIFO is full at count==FIFO_DEPTH and empty at count==0.
- TX FSM states: IDLE, START, WAIT_DONE.
  - IDLE: if en=1 and fifoCount>0, pop the head into the txIn register, set txStart=1, go to START.
  - START: hold txStart=1 and txIn stable until txBusy=1 is sampled, then txStart=0 and go to WAIT_DONE.
  - WAIT_DONE: wait for txBusy=0, then go to IDLE. A new pop is allowed on the next cycle.
- Latency: capture edge sampled at cycle N → fifoCount updated at N+1 → txStart high at N+2 (en=1, FSM idle, FIFO previously empty).
- txEn = en | (state != IDLE). An in-flight byte always finishes; dropping en never aborts START or WAIT_DONE.
- en=0: no pops. Captures still fill the FIFO, and overflow can still set.
- txIn holds the last transmitted byte after completion; it changes only on a pop.
- Back-to-back: FIFO bytes go out in arrival order with no gaps beyond the IDLE→START cycle.

Test Plan:
1. Single echo (CLOCK_RATE 12 MHz, 9600 baud, XOR_MASK=0): peer Uart8 sends 8'b10001010 → responder retransmits 8'b10001010; peer rxOut matches; fifoCount returns to 0; idle=1; errCount=0.
2. Mask + burst (XOR_MASK=8'hFF): peer sends 8'h00, 8'h55, 8'hA5 back-to-back → echoes are 8'hFF, 8'hAA, 8'h5A in order; fifoCount peaks ≥1; overflow=0.
3. Overflow (FIFO_DEPTH=4): en=0; inject 5 rxDone edges with bytes 8'h01..8'h05 → fifoCount=4, overflow=1. Raise en → exactly 8'h01..8'h04 transmitted.
4. Error handling (DROP_ON_ERR=1): 3 rxDone edges with rxErr=1, then byte 8'h3C with rxErr=0 → errCount=3; only 8'h3C is echoed.
5. Level hold: rxDone held high 50 cycles with rxOut=8'h7E → one push only; fifoCount=1.
6. Reset mid-flight: pull reset low while in WAIT_DONE with fifoCount=2 → all outputs at reset values within the same cycle; after release, no transmission until a new capture.

Source files
------------

// File: rtl/uart8_echo_responder_if.sv
// uart8_echo_responder_if: rx/tx handshake bundle between the echo responder and its Uart8.
interface uart8_echo_responder_if;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxOut;
    logic       txBusy;
    logic       txDone;
    logic       txEn;
    logic       txStart;
    logic [7:0] txIn;
    modport master (
        input  rxDone, rxErr, rxOut, txBusy, txDone,
        output txEn, txStart, txIn
    );
    modport slave (
        output rxDone, rxErr, rxOut, txBusy, txDone,
        input  txEn, txStart, txIn
    );
endinterface

// File: rtl/uart8_echo_responder.sv
// uart8_echo_responder: buffers cleanly received Uart8 bytes and echoes them back XORed with a mask.
module uart8_echo_responder #(
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] XOR_MASK    = 8'h00,
    parameter bit         DROP_ON_ERR = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    uart8_echo_responder_if.master      uart,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount,
    output logic                        overflow,
    output logic [7:0]                  errCount,
    output logic                        idle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} stateT;

    stateT         state, stateNext;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [7:0]    txInQ;
    logic          rxDoneQ, capture, push, pop, full, accept;

    assign capture = uart.rxDone & ~rxDoneQ;
    assign push    = capture & ~(uart.rxErr & DROP_ON_ERR);
    assign full    = fifoCount == FULL_COUNT;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign accept  = push & (~full | pop);

    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (en && fifoCount != '0) begin
                    pop       = 1'b1;
                    stateNext = START;
                end
            end
            START:     stateNext = uart.txBusy ? WAIT_DONE : START;
            WAIT_DONE: stateNext = uart.txBusy ? WAIT_DONE : IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rxDoneQ   <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
            errCount  <= '0;
            txInQ     <= '0;
        end else begin
            state     <= stateNext;
            rxDoneQ   <= uart.rxDone;
            fifoCount <= fifoCount + (AW+1)'(accept) - (AW+1)'(pop);
            if (accept)
                wrPtr <= wrPtr + 1'b1;
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
                txInQ <= mem[rdPtr];
            end
            if (push && full && !pop)
                overflow <= 1'b1;
            if (capture && uart.rxErr && errCount != 8'hFF)
                errCount <= errCount + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wrPtr] <= uart.rxOut ^ XOR_MASK;
    end

    // The reset term keeps txEn low while reset is held even if en is already high.
    assign uart.txEn    = reset & (en | (state != IDLE));
    assign uart.txStart = state == START;
    assign uart.txIn    = txInQ;
    assign idle         = (state == IDLE) && (fifoCount == '0);
endmodule

// File: tb/tb_uart8_echo_responder.sv
// tb_uart8_echo_responder: scoreboard bench with a behavioural Uart8 peer answering the responder.
`timescale 1ns/1ps
module tb_uart8_echo_responder;
    localparam int         DEPTH       = 4;
    localparam logic [7:0] MASK        = 8'h5A;
    localparam int         BUSY_CYCLES = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [2:0] fifoCount;
    logic       overflow;
    logic [7:0] errCount;
    logic       idle;

    logic [7:0] expQ [$];
    int vectors = 0, miscompares = 0;
    int cyc = 0, capCyc = 0, txCyc = 0, txCount = 0, peak = 0, busyLeft = 0, t0 = 0;

    uart8_echo_responder_if bus();

    uart8_echo_responder #(
        .FIFO_DEPTH(DEPTH),
        .XOR_MASK(MASK),
        .DROP_ON_ERR(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .uart(bus.master),
        .fifoCount(fifoCount),
        .overflow(overflow),
        .errCount(errCount),
        .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "TxEn"}, bus.txEn, 0);
        checkVal({tag, "TxStart"}, bus.txStart, 0);
        checkVal({tag, "TxIn"}, bus.txIn, 0);
        checkVal({tag, "FifoCount"}, fifoCount, 0);
        checkVal({tag, "Overflow"}, overflow, 0);
        checkVal({tag, "ErrCount"}, errCount, 0);
        checkVal({tag, "Idle"}, idle, 1);
    endtask

    // Single-cycle rxDone pulse; the echo is queued only when the responder should keep the byte.
    task automatic sendByte(input logic [7:0] b, input logic err, input logic expectEcho);
        @(posedge clk); #1;
        bus.rxOut  = b;
        bus.rxErr  = err;
        bus.rxDone = 1'b1;
        capCyc = cyc;
        if (expectEcho)
            expQ.push_back(b ^ MASK);
        @(posedge clk); #1;
        bus.rxDone = 1'b0;
        bus.rxErr  = 1'b0;
        @(posedge clk);
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (n < 400 && !(expQ.size() == 0 && idle && !bus.txBusy)) begin
            @(posedge clk); #2;
            n++;
        end
        checkVal(tag, expQ.size(), 0);
    endtask

    // Uart8 transmitter model: takes txStart, stays busy for a fixed time, recovers on reset.
    initial begin
        bus.txBusy = 1'b0;
        bus.txDone = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.txDone = 1'b0;
            if (int'(fifoCount) > peak)
                peak = int'(fifoCount);
            if (!reset) begin
                busyLeft   = 0;
                bus.txBusy = 1'b0;
            end else if (busyLeft > 0) begin
                busyLeft--;
                if (busyLeft == 0) begin
                    bus.txBusy = 1'b0;
                    bus.txDone = 1'b1;
                end
            end else if (bus.txStart && bus.txEn) begin
                txCount++;
                txCyc = cyc;
                if (expQ.size() == 0)
                    checkVal("spuriousTx", {24'b0, bus.txIn}, 32'hFFFF_FFFF);
                else
                    checkVal("echoByte", {24'b0, bus.txIn}, {24'b0, expQ.pop_front()});
                bus.txBusy = 1'b1;
                busyLeft   = BUSY_CYCLES;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rxDone = 1'b0;
        bus.rxErr  = 1'b0;
        bus.rxOut  = 8'h00;
        en    = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkResetOutputs("por");
        reset = 1'b1;

        // Single echo with latency check
        sendByte(8'h8A, 1'b0, 1'b1);
        waitDrain("t1Drain");
        checkVal("t1Latency", txCyc - capCyc, 2);
        checkVal("t1FifoCount", fifoCount, 0);
        checkVal("t1Idle", idle, 1);
        checkVal("t1ErrCount", errCount, 0);
        checkVal("t1TxInHeld", bus.txIn, 8'h8A ^ MASK);

        // Back-to-back burst
        peak = 0;
        sendByte(8'h00, 1'b0, 1'b1);
        sendByte(8'h55, 1'b0, 1'b1);
        sendByte(8'hA5, 1'b0, 1'b1);
        waitDrain("t2Drain");
        checkVal("t2Peak", peak >= 1, 1);
        checkVal("t2Overflow", overflow, 0);

        // Overflow with en low
        en = 1'b0;
        t0 = txCount;
        for (int i = 1; i <= 5; i++)
            sendByte(8'(i), 1'b0, i <= DEPTH);
        #2;
        checkVal("t3FifoCount", fifoCount, DEPTH);
        checkVal("t3Overflow", overflow, 1);
        checkVal("t3TxEnLow", bus.txEn, 0);
        checkVal("t3NoTx", txCount - t0, 0);
        en = 1'b1;
        waitDrain("t3Drain");
        checkVal("t3TxCount", txCount - t0, DEPTH);
        checkVal("t3OverflowSticky", overflow, 1);

        // Framing errors are counted and dropped
        t0 = txCount;
        for (int i = 0; i < 3; i++)
            sendByte(8'hE0 + 8'(i), 1'b1, 1'b0);
        sendByte(8'h3C, 1'b0, 1'b1);
        waitDrain("t4Drain");
        checkVal("t4ErrCount", errCount, 3);
        checkVal("t4TxCount", txCount - t0, 1);

        // rxDone held high captures once
        en = 1'b0;
        t0 = txCount;
        @(posedge clk); #1;
        bus.rxOut  = 8'h7E;
        bus.rxDone = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        bus.rxDone = 1'b0;
        @(posedge clk); #2;
        checkVal("t5FifoCount", fifoCount, 1);
        expQ.push_back(8'h7E ^ MASK);
        en = 1'b1;
        waitDrain("t5Drain");
        checkVal("t5TxCount", txCount - t0, 1);

        // Asynchronous reset while in WAIT_DONE with two bytes queued
        en = 1'b0;
        sendByte(8'h11, 1'b0, 1'b1);
        sendByte(8'h22, 1'b0, 1'b1);
        sendByte(8'h33, 1'b0, 1'b1);
        en = 1'b1;
        for (int n = 0; n < 20 && !bus.txBusy; n++) begin
            @(posedge clk); #2;
        end
        checkVal("t6Busy", bus.txBusy, 1);
        @(posedge clk); #2;
        checkVal("t6FifoCount", fifoCount, 2);
        checkVal("t6NotIdle", idle, 0);
        #1 reset = 1'b0;
        #1 checkResetOutputs("midReset");
        expQ.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        t0 = txCount;
        repeat (40) @(posedge clk);
        #2;
        checkVal("t6NoTxAfterReset", txCount - t0, 0);
        checkVal("t6IdleAfterReset", idle, 1);
        sendByte(8'h66, 1'b0, 1'b1);
        waitDrain("t6Drain");
        checkVal("t6Recovered", txCount - t0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
